// File: rtl/osd_dir_buffer_if.sv
// ---------------------------------------------------------------------------
// osd_dir_buffer_if
// Bundles every non-clock signal of the directory buffer.
//   slave  modport : the buffer itself (osd_dir_buffer)
//   master modport : the environment (FAT reader + OSD, or a testbench)
// Signals:
//   scan_start  pulse, discard listing and clear the store
//   scan_done   pulse, writer has finished the listing
//   wr_valid / wr_ready / wr_chr / wr_eoe   writer character stream
//   rd_en / rd_row / rd_col / rd_chr        OSD fetch port, 1-cycle latency
//   dir_len     completed entries
//   busy        clearing or filling
//   overflow    sticky, an entry was dropped because the store was full
//   dbg_state   current FSM state (0 IDLE, 1 CLEAR, 2 FILL, 3 READY)
// ---------------------------------------------------------------------------
interface osd_dir_buffer_if;
    logic       scan_start;
    logic       scan_done;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_chr;
    logic       wr_eoe;
    logic       rd_en;
    logic [7:0] rd_row;
    logic [3:0] rd_col;
    logic [7:0] rd_chr;
    logic [5:0] dir_len;
    logic       busy;
    logic       overflow;
    logic [1:0] dbg_state;

    modport slave (
        input  scan_start, scan_done, wr_valid, wr_chr, wr_eoe,
        input  rd_en, rd_row, rd_col,
        output wr_ready, rd_chr, dir_len, busy, overflow, dbg_state
    );

    modport master (
        output scan_start, scan_done, wr_valid, wr_chr, wr_eoe,
        output rd_en, rd_row, rd_col,
        input  wr_ready, rd_chr, dir_len, busy, overflow, dbg_state
    );
endinterface

// File: rtl/osd_dir_buffer.sv
// ---------------------------------------------------------------------------
// osd_dir_buffer
// Directory character store shared by the SD FAT reader (writer) and the
// ASCII OSD (reader). One single-port RAM of MAX_ENTRIES x NAME_LEN chars.
// The OSD read always owns the RAM in the cycle it asks for it; clearing and
// writer traffic only use cycles where rd_en is low.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    osd_dir_buffer_if.slave (writer stream, OSD fetch, status)
//
// Writer handshake: a character (or end-of-entry marker when wr_eoe=1) is
// transferred on every rising edge where wr_valid && wr_ready. The writer
// keeps wr_valid/wr_chr/wr_eoe stable until that happens; wr_ready may drop
// at any cycle (OSD fetch, scan_start) without loss, the beat simply retries.
// ---------------------------------------------------------------------------
module osd_dir_buffer #(
    parameter int MAX_ENTRIES = 32,
    parameter int NAME_LEN    = 16
) (
    input  logic              clk,
    input  logic              reset,
    osd_dir_buffer_if.slave   bus
);

    localparam int ROW_W     = $clog2(MAX_ENTRIES);
    localparam int ROW_CW    = ROW_W + 1;           // row counter must reach MAX_ENTRIES
    localparam int ADDR_W    = ROW_W + 4;
    localparam int DEPTH     = MAX_ENTRIES * NAME_LEN;
    localparam int LAST_ADDR = DEPTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_FILL  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
    logic [ROW_CW-1:0]   row_q, row_d;
    logic [4:0]          col_q, col_d;
    logic                ovf_q, ovf_d;
    logic                rd_seen_q, rd_seen_d;
    logic                rd_oob_q, rd_oob_d;
    logic [7:0]          rd_data_q;

    logic [7:0]          mem [DEPTH];

    logic                wr_ready;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [7:0]          ram_wdata;
    logic [ADDR_W-1:0]   ram_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   wr_addr;
    logic                rd_oob;

    assign rd_addr  = {bus.rd_row[ROW_W-1:0], bus.rd_col};
    assign wr_addr  = {row_q[ROW_W-1:0], col_q[3:0]};
    assign rd_oob   = (bus.rd_row >= 8'(MAX_ENTRIES));
    // The read port owns the address whenever rd_en is high; ram_we is never
    // raised in such a cycle, so read and write never collide.
    assign ram_addr = bus.rd_en ? rd_addr : ram_waddr;

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        row_d     = row_q;
        col_d     = col_q;
        ovf_d     = ovf_q;
        wr_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = 8'h20;

        if (bus.scan_start) begin
            // Restart wins over everything, including a pending write beat.
            state_d = ST_CLEAR;
            clr_d   = '0;
            row_d   = '0;
            col_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end

                ST_CLEAR: begin
                    if (!bus.rd_en) begin
                        ram_we    = 1'b1;
                        ram_waddr = clr_q;
                        if (clr_q == ADDR_W'(LAST_ADDR)) begin
                            state_d = ST_FILL;
                            clr_d   = '0;
                            row_d   = '0;
                            col_d   = '0;
                        end else begin
                            clr_d = clr_q + 1'b1;
                        end
                    end
                end

                ST_FILL: begin
                    wr_ready = !bus.rd_en;
                    if (bus.wr_valid && wr_ready) begin
                        if (bus.wr_eoe) begin
                            if (row_q < ROW_CW'(MAX_ENTRIES)) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                            col_d = '0;
                        end else if (col_q < 5'(NAME_LEN)) begin
                            // Once the store is full, chars of the dropped
                            // entry must not alias onto row 0.
                            if (row_q < ROW_CW'(MAX_ENTRIES)) begin
                                ram_we    = 1'b1;
                                ram_waddr = wr_addr;
                                ram_wdata = bus.wr_chr;
                            end
                            col_d = col_q + 1'b1;
                        end
                    end
                    if (bus.scan_done) begin
                        state_d = ST_READY;
                    end
                end

                ST_READY: begin
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Read-side bookkeeping: rd_chr reads as a space until the first fetch
    // and for any out-of-range row; both hold while rd_en is low.
    always_comb begin
        rd_seen_d = rd_seen_q | bus.rd_en;
        rd_oob_d  = bus.rd_en ? rd_oob : rd_oob_q;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            clr_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            ovf_q     <= 1'b0;
            rd_seen_q <= 1'b0;
            rd_oob_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            row_q     <= row_d;
            col_q     <= col_d;
            ovf_q     <= ovf_d;
            rd_seen_q <= rd_seen_d;
            rd_oob_q  <= rd_oob_d;
        end
    end

    // Single-port RAM, no reset on the array or its read register.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        if (bus.rd_en) begin
            rd_data_q <= mem[ram_addr];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Completed entries equal the fill row, since both advance together on
    // an accepted end-of-entry beat.
    assign bus.dir_len   = 6'(row_q);
    assign bus.wr_ready  = wr_ready;
    assign bus.busy      = (state_q == ST_CLEAR) || (state_q == ST_FILL);
    assign bus.overflow  = ovf_q;
    assign bus.rd_chr    = (!rd_seen_q || rd_oob_q) ? 8'h20 : rd_data_q;
    assign bus.dbg_state = state_q;

endmodule
